mem_port_responder: RTL and testbench

// Responder side of the core's instruction/data memory interface. Serves the

---
 rtl/mem_port_responder.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_responder.sv
// mem_port_responder: responder side of the core's instruction/data memory
// interface. The fetch and load/store ports share one synchronous single-port
// RAM with a 1-cycle read latency. Data accesses at or above IO_BASE are sent
// to a req/ack I/O bus instead. core_stall serialises conflicts between the
// two ports. ADDR_WIDTH must be 16 or less.
module mem_port_responder #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [15:0] IO_BASE    = 16'hff00,
  parameter int          TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           core_iaddr,
  output logic [15:0]           core_idata,
  input  logic [15:0]           core_daddr,
  input  logic [15:0]           core_dwdata,
  input  logic                  core_dread_en,
  input  logic                  core_dwrite_en,
  output logic [15:0]           core_drdata,
  output logic                  core_stall,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  output logic                  ram_we,
  input  logic [15:0]           ram_rdata,
  output logic                  io_req,
  output logic                  io_we,
  output logic [15:0]           io_addr,
  output logic [15:0]           io_wdata,
  input  logic [15:0]           io_rdata,
  input  logic                  io_ack,
  output logic                  io_timeout
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_IO_DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [15:0] idata_hold_r;
  logic [15:0] drdata_hold_r;
  logic        is_load_r;
  logic        io_req_r;
  logic        io_we_r;
  logic [15:0] io_addr_r;
  logic [15:0] io_wdata_r;
  logic        io_timeout_r;
  logic [7:0]  count_r;

  logic        memop_s;
  logic        is_io_s;
  logic        ram_data_acc_s;

  // Classify the execute-stage request. Stall and RAM steering derive from
  // state, memop and is_io only, never from core_iaddr, so no loop forms
  // through the core's next-PC logic.
  always_comb begin
    memop_s        = core_dread_en | core_dwrite_en;
    is_io_s        = (core_daddr >= IO_BASE);
    ram_data_acc_s = (state_r == ST_IDLE) && memop_s && !is_io_s;
  end

  // Stall generation: one cycle for a RAM data access, the whole wait for I/O.
  always_comb begin
    core_stall = 1'b0;
    if (reset) begin
      core_stall = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:    core_stall = memop_s;
        ST_DATA:    core_stall = 1'b0;
        ST_IO_WAIT: core_stall = 1'b1;
        ST_IO_DONE: core_stall = 1'b0;
        default:    core_stall = 1'b0;
      endcase
    end
  end

  // RAM port steering: the data port takes the RAM only for a non-I/O access
  // in IDLE. In every other cycle fetch owns the RAM.
  always_comb begin
    ram_wdata = core_dwdata;
    ram_we    = 1'b0;
    if (ram_data_acc_s) begin
      ram_addr = core_daddr[ADDR_WIDTH-1:0];
      ram_we   = core_dwrite_en & ~reset;
    end else begin
      ram_addr = core_iaddr[ADDR_WIDTH-1:0];
      ram_we   = 1'b0;
    end
  end

  // Instruction return. RAM data is live only in IDLE. After a data access,
  // the instruction captured on the stall cycle is replayed.
  always_comb begin
    core_idata = 16'h0000;
    if (reset) begin
      core_idata = 16'h0000;
    end else if (state_r == ST_IDLE) begin
      core_idata = ram_rdata;
    end else begin
      core_idata = idata_hold_r;
    end
  end

  assign core_drdata = drdata_hold_r;
  assign io_req      = io_req_r;
  assign io_we       = io_we_r;
  assign io_addr     = io_addr_r;
  assign io_wdata    = io_wdata_r;
  assign io_timeout  = io_timeout_r;

  // Port arbitration FSM with the registered I/O request and the hold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      idata_hold_r  <= 16'h0000;
      drdata_hold_r <= 16'h0000;
      is_load_r     <= 1'b0;
      io_req_r      <= 1'b0;
      io_we_r       <= 1'b0;
      io_addr_r     <= 16'h0000;
      io_wdata_r    <= 16'h0000;
      io_timeout_r  <= 1'b0;
      count_r       <= 8'd0;
    end else begin
      io_timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (memop_s) begin
            idata_hold_r <= ram_rdata;
            is_load_r    <= core_dread_en;
            if (is_io_s) begin
              io_req_r   <= 1'b1;
              io_we_r    <= core_dwrite_en;
              io_addr_r  <= core_daddr;
              io_wdata_r <= core_dwdata;
              count_r    <= 8'd0;
              state_r    <= ST_IO_WAIT;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (is_load_r) begin
            drdata_hold_r <= ram_rdata;
          end
          state_r <= ST_IDLE;
        end
        ST_IO_WAIT: begin
          if (io_ack) begin
            drdata_hold_r <= io_rdata;
            io_req_r      <= 1'b0;
            io_we_r       <= 1'b0;
            state_r       <= ST_IO_DONE;
          end else if (count_r == TIMEOUT_C) begin
            drdata_hold_r <= 16'hffff;
            io_req_r      <= 1'b0;
            io_we_r       <= 1'b0;
            io_timeout_r  <= 1'b1;
            state_r       <= ST_IO_DONE;
          end else begin
            count_r <= count_r + 8'd1;
          end
        end
        ST_IO_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// Testbench for mem_port_responder. Expected values go into a queue together
// with the cycle they apply to. A separate negedge monitor pops and compares
// each entry when its cycle arrives.
module tb_mem_port_responder;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] core_iaddr, core_idata, core_daddr, core_dwdata, core_drdata;
  logic        core_dread_en, core_dwrite_en, core_stall;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic        io_req, io_we, io_ack, io_timeout;
  logic [15:0] io_addr, io_wdata, io_rdata;

  logic [15:0] mem [0:65535];

  mem_port_responder #(.ADDR_WIDTH(16), .IO_BASE(16'hff00), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .core_iaddr(core_iaddr), .core_idata(core_idata),
    .core_daddr(core_daddr), .core_dwdata(core_dwdata),
    .core_dread_en(core_dread_en), .core_dwrite_en(core_dwrite_en),
    .core_drdata(core_drdata), .core_stall(core_stall),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .io_timeout(io_timeout)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model with a 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  // Cycle counter used to tag the expectations.
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {S_IDATA, S_DRDATA, S_STALL, S_RAM_WE, S_RAM_ADDR,
                    S_IO_REQ, S_IO_WE, S_IO_ADDR, S_IO_WDATA, S_IO_TO} sel_t;
  typedef struct {
    int          cyc;
    sel_t        sel;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] get_sig(sel_t s);
    case (s)
      S_IDATA:    return core_idata;
      S_DRDATA:   return core_drdata;
      S_STALL:    return {15'd0, core_stall};
      S_RAM_WE:   return {15'd0, ram_we};
      S_RAM_ADDR: return ram_addr;
      S_IO_REQ:   return {15'd0, io_req};
      S_IO_WE:    return {15'd0, io_we};
      S_IO_ADDR:  return io_addr;
      S_IO_WDATA: return io_wdata;
      S_IO_TO:    return {15'd0, io_timeout};
      default:    return 16'hxxxx;
    endcase
  endfunction

  task automatic push(input int off, input sel_t s, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + off;
    e.sel  = s;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation that is due in the current cycle.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        n_cmp++;
        if (exp_q[i].cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: cycle %0d expectation was not sampled (got none, required %h)",
                   exp_q[i].name, exp_q[i].cyc, exp_q[i].val);
        end else if (get_sig(exp_q[i].sel) !== exp_q[i].val) begin
          n_bad++;
          $display("FAIL %s: cycle %0d got %h required %h",
                   exp_q[i].name, cyc, get_sig(exp_q[i].sel), exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  // Global time limit so that the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    mem[16'h0040] = 16'hbeef;

    // Reset with a pending load/store on the inputs.
    reset = 1'b1; core_iaddr = 16'h0000; core_daddr = 16'h0040; core_dwdata = 16'h5555;
    core_dread_en = 1'b1; core_dwrite_en = 1'b1; io_rdata = 16'h0000; io_ack = 1'b0;
    step();
    push(0, S_STALL, 16'h0, "rst_stall");   push(0, S_RAM_WE, 16'h0, "rst_ram_we");
    push(0, S_IO_REQ, 16'h0, "rst_io_req"); push(0, S_IDATA, 16'h0, "rst_idata");
    push(0, S_DRDATA, 16'h0, "rst_drdata"); push(0, S_IO_TO, 16'h0, "rst_io_to");
    step(); step();
    reset = 1'b0; core_dread_en = 1'b0; core_dwrite_en = 1'b0;

    // Plain fetch.
    for (int i = 0; i < 3; i++) begin
      core_iaddr = 16'(i);
      push(0, S_STALL, 16'h0, "fetch_stall");
      push(1, S_IDATA, 16'h1000 + 16'(i), "fetch_idata");
      step();
    end

    // RAM load from 0x0040.
    core_iaddr = 16'h0005; step();
    core_iaddr = 16'h0006; core_dread_en = 1'b1; core_daddr = 16'h0040;
    push(0, S_STALL, 16'h1, "ld_stall");       push(0, S_IDATA, 16'h1005, "ld_idata_stall");
    push(0, S_RAM_ADDR, 16'h0040, "ld_addr");  push(0, S_RAM_WE, 16'h0, "ld_we");
    push(1, S_STALL, 16'h0, "ld_release");     push(1, S_IDATA, 16'h1005, "ld_idata_hold");
    push(2, S_DRDATA, 16'hbeef, "ld_drdata");  push(2, S_IDATA, 16'h1006, "ld_idata_next");
    push(2, S_STALL, 16'h0, "ld_no_restall");
    step(); step();
    core_dread_en = 1'b0; core_iaddr = 16'h0007; step();

    // RAM store of 0x1234 to 0x0041, then load it back.
    core_iaddr = 16'h0008; core_dwrite_en = 1'b1; core_daddr = 16'h0041; core_dwdata = 16'h1234;
    push(0, S_STALL, 16'h1, "st_stall");       push(0, S_RAM_WE, 16'h1, "st_we");
    push(0, S_RAM_ADDR, 16'h0041, "st_addr");  push(0, S_IDATA, 16'h1007, "st_idata");
    push(1, S_RAM_WE, 16'h0, "st_we_once");    push(1, S_STALL, 16'h0, "st_release");
    push(2, S_DRDATA, 16'hbeef, "st_drdata_kept");
    step(); step();
    core_dwrite_en = 1'b0; core_dread_en = 1'b1;
    push(0, S_STALL, 16'h1, "ldb_stall");      push(0, S_IDATA, 16'h1008, "ldb_idata");
    push(2, S_DRDATA, 16'h1234, "ldb_drdata");
    step(); step();
    core_dread_en = 1'b0; core_iaddr = 16'h0009; step();

    // I/O load from 0xff10, acked in the third wait cycle.
    core_iaddr = 16'h000a; core_dread_en = 1'b1; core_daddr = 16'hff10;
    push(0, S_STALL, 16'h1, "iol_stall0");     push(0, S_RAM_WE, 16'h0, "iol_no_ram_we");
    push(0, S_IO_REQ, 16'h0, "iol_req_reg");   push(0, S_RAM_ADDR, 16'h000a, "iol_ram_addr");
    push(1, S_IO_REQ, 16'h1, "iol_req");       push(1, S_IO_ADDR, 16'hff10, "iol_io_addr");
    push(1, S_IO_WE, 16'h0, "iol_io_we");      push(1, S_IDATA, 16'h1009, "iol_idata_hold");
    push(1, S_STALL, 16'h1, "iol_stall1");     push(2, S_STALL, 16'h1, "iol_stall2");
    push(3, S_STALL, 16'h1, "iol_stall3");     push(3, S_IO_REQ, 16'h1, "iol_req_held");
    push(4, S_STALL, 16'h0, "iol_release");    push(4, S_IO_REQ, 16'h0, "iol_req_drop");
    push(4, S_IDATA, 16'h1009, "iol_idata_done"); push(5, S_DRDATA, 16'h00a5, "iol_drdata");
    step(); step(); step();
    io_ack = 1'b1; io_rdata = 16'h00a5; step();
    io_ack = 1'b0; io_rdata = 16'h0000; step();
    core_dread_en = 1'b0; step();

    // I/O store to 0xff20 acked in the first wait cycle.
    core_dwrite_en = 1'b1; core_daddr = 16'hff20; core_dwdata = 16'h5a5a;
    push(0, S_STALL, 16'h1, "ios_stall0");     push(1, S_IO_REQ, 16'h1, "ios_req");
    push(1, S_IO_WE, 16'h1, "ios_io_we");      push(1, S_IO_ADDR, 16'hff20, "ios_io_addr");
    push(1, S_IO_WDATA, 16'h5a5a, "ios_wdata"); push(1, S_STALL, 16'h1, "ios_stall1");
    push(2, S_STALL, 16'h0, "ios_release");    push(2, S_IO_REQ, 16'h0, "ios_req_drop");
    step();
    io_ack = 1'b1; step();
    io_ack = 1'b0; core_dwrite_en = 1'b0; step();

    // I/O load with no ack: timeout.
    core_dread_en = 1'b1; core_daddr = 16'hff40;
    push(0, S_STALL, 16'h1, "to_stall0");      push(1, S_IO_REQ, 16'h1, "to_req");
    push(1 + TO / 2, S_STALL, 16'h1, "to_stall_mid");
    push(1 + TO, S_STALL, 16'h1, "to_stall_last"); push(1 + TO, S_IO_TO, 16'h0, "to_not_yet");
    push(1 + TO, S_IO_REQ, 16'h1, "to_req_last");  push(2 + TO, S_IO_TO, 16'h1, "to_pulse");
    push(2 + TO, S_STALL, 16'h0, "to_release");    push(2 + TO, S_IO_REQ, 16'h0, "to_req_drop");
    push(3 + TO, S_IO_TO, 16'h0, "to_pulse_end");  push(3 + TO, S_DRDATA, 16'hffff, "to_drdata");
    repeat (2 + TO) step();
    core_dread_en = 1'b0; step(); step();

    // Reset during IO_WAIT; a late ack is ignored.
    core_dread_en = 1'b1; core_daddr = 16'hff30;
    push(0, S_STALL, 16'h1, "rio_stall0");     push(1, S_IO_REQ, 16'h1, "rio_req");
    push(1, S_STALL, 16'h1, "rio_stall1");
    step(); step();
    reset = 1'b1; core_dread_en = 1'b0; core_iaddr = 16'h0000;
    #1;
    push(0, S_IO_REQ, 16'h0, "rio_req_drop");  push(0, S_STALL, 16'h0, "rio_stall_drop");
    push(0, S_IDATA, 16'h0, "rio_idata");      push(0, S_DRDATA, 16'h0, "rio_drdata");
    step();
    reset = 1'b0; step();
    io_ack = 1'b1; io_rdata = 16'h1111; core_iaddr = 16'h0001;
    push(0, S_STALL, 16'h0, "late_stall");     push(0, S_IDATA, 16'h1000, "late_idata0");
    push(1, S_DRDATA, 16'h0, "late_drdata");   push(1, S_IDATA, 16'h1001, "late_idata1");
    push(1, S_IO_REQ, 16'h0, "late_req");      push(1, S_STALL, 16'h0, "late_stall2");
    step();
    io_ack = 1'b0; io_rdata = 16'h0000; core_iaddr = 16'h0002;
    push(1, S_IDATA, 16'h1002, "late_idata2");
    repeat (4) step();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
